arm_id_pipe_stage: RTL and testbench

//  Parametrised ARM decode stage: register file, condition check, control decode and ID/EX pipeline register.

---
 rtl/arm_pkg.sv | 81 ++++++++
 rtl/arm_register_file.sv | 36 +++
 rtl/arm_id_pipe_stage.sv | 117 +++++++++++
 tb/tb_arm_id_pipe_stage.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: shared decode constants, control bundle and condition evaluation for the ARM core
package arm_pkg;
   localparam logic [3:0] EXE_NOP = 4'b0000;
   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_MVN = 4'b1001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_CMP = 4'b0100;
   localparam logic [3:0] EXE_TST = 4'b0110;
   localparam logic [3:0] EXE_MEM = 4'b0010;
   localparam logic [3:0] OPC_AND = 4'b0000;
   localparam logic [3:0] OPC_EOR = 4'b0001;
   localparam logic [3:0] OPC_SUB = 4'b0010;
   localparam logic [3:0] OPC_ADD = 4'b0100;
   localparam logic [3:0] OPC_ADC = 4'b0101;
   localparam logic [3:0] OPC_SBC = 4'b0110;
   localparam logic [3:0] OPC_TST = 4'b1000;
   localparam logic [3:0] OPC_CMP = 4'b1010;
   localparam logic [3:0] OPC_ORR = 4'b1100;
   localparam logic [3:0] OPC_MOV = 4'b1101;
   localparam logic [3:0] OPC_MVN = 4'b1111;
   localparam logic [1:0] MODE_DP  = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;
   typedef enum logic [3:0] {
      COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
      COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
   } cond_e;
   typedef struct packed {
      logic       valid;
      logic       s;
      logic       b;
      logic       memR;
      logic       memW;
      logic       wbEn;
      logic [3:0] exeCmd;
   } ctrl_t;
   function automatic logic cond_pass(input cond_e cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: return z;
         COND_NE: return !z;
         COND_CS: return c;
         COND_CC: return !c;
         COND_MI: return n;
         COND_PL: return !n;
         COND_VS: return v;
         COND_VC: return !v;
         COND_HI: return c && !z;
         COND_LS: return !c || z;
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return !z && (n == v);
         COND_LE: return z || (n != v);
         COND_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
   function automatic logic [3:0] dp_exe(input logic [3:0] opcode);
      case (opcode)
         OPC_MOV: return EXE_MOV;
         OPC_MVN: return EXE_MVN;
         OPC_ADD: return EXE_ADD;
         OPC_ADC: return EXE_ADC;
         OPC_SUB: return EXE_SUB;
         OPC_SBC: return EXE_SBC;
         OPC_AND: return EXE_AND;
         OPC_ORR: return EXE_ORR;
         OPC_EOR: return EXE_EOR;
         OPC_CMP: return EXE_CMP;
         OPC_TST: return EXE_TST;
         default: return EXE_NOP;
      endcase
   endfunction
endpackage

// File: rtl/arm_register_file.sv
// arm_register_file: REG_CNT x DATA_W registers, two read ports with write-back bypass, one write port
module arm_register_file
   import arm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_CNT = 16,
   parameter bit RF_INIT_IDX = 1'b1,
   localparam int REG_AW = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rdAddrA,
   input  logic [REG_AW-1:0] rdAddrB,
   input  logic              wrEn,
   input  logic [REG_AW-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   output logic [DATA_W-1:0] rdDataA,
   output logic [DATA_W-1:0] rdDataB
);
   logic [DATA_W-1:0] regs [REG_CNT];
   logic              wrOk;
   assign wrOk = wrEn && (int'(wrAddr) < REG_CNT);
   // Storage: reset reloads the initial image, otherwise accept in-range write-backs
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < REG_CNT; i++) regs[i] <= RF_INIT_IDX ? DATA_W'(i) : '0;
      end else if (wrOk) begin
         regs[wrAddr] <= wrData;
      end
   end
   // Reads forward a value retiring this cycle so decode never sees a stale register
   always_comb begin
      rdDataA = (wrOk && wrAddr == rdAddrA) ? wrData : (int'(rdAddrA) < REG_CNT) ? regs[rdAddrA] : '0;
      rdDataB = (wrOk && wrAddr == rdAddrB) ? wrData : (int'(rdAddrB) < REG_CNT) ? regs[rdAddrB] : '0;
   end
endmodule

// File: rtl/arm_id_pipe_stage.sv
// arm_id_pipe_stage: ARM decode stage with register read, condition check and ID/EX register
module arm_id_pipe_stage
   import arm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_CNT = 16,
   parameter bit RF_INIT_IDX = 1'b1,
   localparam int REG_AW = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic              hazard,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [31:0]       instr_in,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   input  logic [3:0]        status_in,
   output logic              valid_out,
   output logic              s_out,
   output logic              b_out,
   output logic              mem_r_out,
   output logic              mem_w_out,
   output logic              wb_en_out,
   output logic [3:0]        exe_cmd,
   output logic [DATA_W-1:0] val_rn,
   output logic [DATA_W-1:0] val_rm,
   output logic [DATA_W-1:0] pc_out,
   output logic [23:0]       imm24,
   output logic [REG_AW-1:0] rd,
   output logic              imm,
   output logic [11:0]       shift_op,
   output logic              carry_out,
   output logic [REG_AW-1:0] src1,
   output logic [REG_AW-1:0] src2,
   output logic              two_src
);
   logic [1:0]        mode;
   logic [3:0]        opcode, dpExe;
   logic              iBit, sBit, isStr, condOk, dpWrites;
   ctrl_t             decCtrl, nextCtrl, ctrlQ;
   logic [DATA_W-1:0] rnValue, rmValue;
   assign mode     = instr_in[27:26];
   assign iBit     = instr_in[25];
   assign opcode   = instr_in[24:21];
   assign sBit     = instr_in[20];
   assign isStr    = (mode == MODE_MEM) && !sBit;
   assign condOk   = cond_pass(cond_e'(instr_in[31:28]), status_in);
   assign dpExe    = dp_exe(opcode);
   assign dpWrites = (dpExe != EXE_NOP) && (opcode != OPC_CMP) && (opcode != OPC_TST);
   // Hazard sources: STR reads Rd as its second operand instead of Rm
   always_comb begin
      src1    = REG_AW'(instr_in[19:16]);
      src2    = isStr ? REG_AW'(instr_in[15:12]) : REG_AW'(instr_in[3:0]);
      two_src = !iBit || isStr;
   end
   arm_register_file #(
      .DATA_W(DATA_W),
      .REG_CNT(REG_CNT),
      .RF_INIT_IDX(RF_INIT_IDX)
   ) regFile (
      .clk(clk),
      .rst(rst),
      .rdAddrA(src1),
      .rdAddrB(src2),
      .wrEn(wb_en),
      .wrAddr(wb_dest),
      .wrData(wb_value),
      .rdDataA(rnValue),
      .rdDataB(rmValue)
   );
   // Control decode; a failed condition turns the instruction into an invalid no-op
   always_comb begin
      decCtrl        = '0;
      decCtrl.valid  = 1'b1;
      decCtrl.s      = (mode == MODE_DP) && (dpExe != EXE_NOP) && sBit;
      decCtrl.b      = mode == MODE_BR;
      decCtrl.memR   = (mode == MODE_MEM) && sBit;
      decCtrl.memW   = isStr;
      decCtrl.wbEn   = (mode == MODE_MEM) ? sBit : (mode == MODE_DP) && dpWrites;
      decCtrl.exeCmd = (mode == MODE_MEM) ? EXE_MEM : (mode == MODE_DP) ? dpExe : EXE_NOP;
      nextCtrl       = condOk ? decCtrl : '0;
   end
   // ID/EX register: reset, then flush bubble, then freeze hold, then hazard bubble, else load
   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrlQ     <= '0;
         val_rn    <= '0;
         val_rm    <= '0;
         pc_out    <= '0;
         imm24     <= '0;
         rd        <= '0;
         imm       <= 1'b0;
         shift_op  <= '0;
         carry_out <= 1'b0;
      end else if (flush || !freeze) begin
         ctrlQ     <= (flush || hazard) ? '0 : nextCtrl;
         val_rn    <= rnValue;
         val_rm    <= rmValue;
         pc_out    <= pc_in;
         imm24     <= instr_in[23:0];
         rd        <= REG_AW'(instr_in[15:12]);
         imm       <= iBit;
         shift_op  <= instr_in[11:0];
         carry_out <= status_in[1];
      end
   end
   assign valid_out = ctrlQ.valid;
   assign s_out     = ctrlQ.s;
   assign b_out     = ctrlQ.b;
   assign mem_r_out = ctrlQ.memR;
   assign mem_w_out = ctrlQ.memW;
   assign wb_en_out = ctrlQ.wbEn;
   assign exe_cmd   = ctrlQ.exeCmd;
endmodule

// File: tb/tb_arm_id_pipe_stage.sv
// tb_arm_id_pipe_stage: directed vectors for the ARM decode stage
module tb_arm_id_pipe_stage;
   logic        clk = 1'b0;
   logic        rst, flush, freeze, hazard, wb_en;
   logic [31:0] pc_in, instr_in, wb_value;
   logic [3:0]  wb_dest, status_in;
   logic        valid_out, s_out, b_out, mem_r_out, mem_w_out, wb_en_out, imm, carry_out, two_src;
   logic [3:0]  exe_cmd, rd, src1, src2;
   logic [31:0] val_rn, val_rm, pc_out;
   logic [23:0] imm24;
   logic [11:0] shift_op;
   int          vectors = 0;
   int          miscompares = 0;
   arm_id_pipe_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .hazard(hazard),
      .pc_in(pc_in), .instr_in(instr_in), .wb_en(wb_en), .wb_dest(wb_dest),
      .wb_value(wb_value), .status_in(status_in), .valid_out(valid_out),
      .s_out(s_out), .b_out(b_out), .mem_r_out(mem_r_out), .mem_w_out(mem_w_out),
      .wb_en_out(wb_en_out), .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm),
      .pc_out(pc_out), .imm24(imm24), .rd(rd), .imm(imm), .shift_op(shift_op),
      .carry_out(carry_out), .src1(src1), .src2(src2), .two_src(two_src)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      rst = 1'b0; flush = 1'b0; freeze = 1'b0; hazard = 1'b0;
      wb_en = 1'b0; wb_dest = '0; wb_value = '0;
      pc_in = '0; instr_in = 32'hE0813002; status_in = 4'b0000;
      tick();
      tick();
      check("rst_valid", valid_out, 1'b0);
      check("rst_wb", wb_en_out, 1'b0);
      check("rst_exe", exe_cmd, 4'h0);
      check("rst_rn", val_rn, 32'h0);
      check("rst_pc", pc_out, 32'h0);
      rst = 1'b1; pc_in = 32'h100;
      #1;
      check("add_src1", src1, 4'd1);
      check("add_src2", src2, 4'd2);
      check("add_two_src", two_src, 1'b1);
      tick();
      check("add_rn", val_rn, 32'd1);
      check("add_rm", val_rm, 32'd2);
      check("add_exe", exe_cmd, 4'b0010);
      check("add_rd", rd, 4'd3);
      check("add_wb", wb_en_out, 1'b1);
      check("add_valid", valid_out, 1'b1);
      check("add_pc", pc_out, 32'h100);
      instr_in = 32'hE3A00014; pc_in = 32'h104;
      #1;
      check("mov_two_src", two_src, 1'b0);
      tick();
      check("mov_exe", exe_cmd, 4'b0001);
      check("mov_imm", imm, 1'b1);
      check("mov_shift", shift_op, 12'h014);
      check("mov_wb", wb_en_out, 1'b1);
      check("mov_rd", rd, 4'd0);
      instr_in = 32'hE0813002; wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'hDEAD;
      tick();
      check("bypass_rn", val_rn, 32'hDEAD);
      check("bypass_rm", val_rm, 32'd2);
      wb_en = 1'b0;
      tick();
      check("written_rn", val_rn, 32'hDEAD);
      instr_in = 32'h03A00014; status_in = 4'b0000;
      tick();
      check("moveq_fail_valid", valid_out, 1'b0);
      check("moveq_fail_wb", wb_en_out, 1'b0);
      check("moveq_fail_exe", exe_cmd, 4'h0);
      status_in = 4'b0100;
      tick();
      check("moveq_pass_valid", valid_out, 1'b1);
      check("moveq_pass_wb", wb_en_out, 1'b1);
      status_in = 4'b0000; instr_in = 32'hE0813002; pc_in = 32'h200;
      tick();
      check("hold_pre_pc", pc_out, 32'h200);
      freeze = 1'b1; instr_in = 32'hE3A00014; pc_in = 32'h204;
      wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h55;
      tick();
      check("freeze_exe", exe_cmd, 4'b0010);
      check("freeze_pc", pc_out, 32'h200);
      check("freeze_rd", rd, 4'd3);
      check("freeze_imm", imm, 1'b0);
      check("freeze_valid", valid_out, 1'b1);
      flush = 1'b1; wb_en = 1'b0;
      tick();
      check("flush_valid", valid_out, 1'b0);
      check("flush_wb", wb_en_out, 1'b0);
      check("flush_exe", exe_cmd, 4'h0);
      freeze = 1'b0; flush = 1'b0; instr_in = 32'hE0813002; pc_in = 32'h208;
      tick();
      check("frozen_write_rm", val_rm, 32'h55);
      check("reload_valid", valid_out, 1'b1);
      freeze = 1'b1; hazard = 1'b1; instr_in = 32'hE3A00014;
      tick();
      check("freeze_over_hazard", valid_out, 1'b1);
      check("freeze_over_hazard_exe", exe_cmd, 4'b0010);
      freeze = 1'b0;
      tick();
      check("hazard_valid", valid_out, 1'b0);
      check("hazard_wb", wb_en_out, 1'b0);
      hazard = 1'b0; instr_in = 32'hE5854000;
      #1;
      check("str_src1", src1, 4'd5);
      check("str_src2", src2, 4'd4);
      check("str_two_src", two_src, 1'b1);
      tick();
      check("str_memw", mem_w_out, 1'b1);
      check("str_memr", mem_r_out, 1'b0);
      check("str_wb", wb_en_out, 1'b0);
      check("str_exe", exe_cmd, 4'b0010);
      check("str_rm", val_rm, 32'd4);
      instr_in = 32'hE5954000;
      tick();
      check("ldr_memr", mem_r_out, 1'b1);
      check("ldr_wb", wb_en_out, 1'b1);
      instr_in = 32'hE0A54006; status_in = 4'b0010;
      tick();
      check("adc_carry", carry_out, 1'b1);
      check("adc_exe", exe_cmd, 4'b0011);
      check("adc_rm", val_rm, 32'd6);
      status_in = 4'b0000; instr_in = 32'hE1510002;
      tick();
      check("cmp_exe", exe_cmd, 4'b0100);
      check("cmp_wb", wb_en_out, 1'b0);
      check("cmp_s", s_out, 1'b1);
      instr_in = 32'hEA000010;
      tick();
      check("b_b", b_out, 1'b1);
      check("b_imm24", imm24, 24'h000010);
      check("b_wb", wb_en_out, 1'b0);
      instr_in = 32'hF0813002;
      tick();
      check("nv_valid", valid_out, 1'b0);
      instr_in = 32'hE0613002;
      tick();
      check("nop_valid", valid_out, 1'b1);
      check("nop_wb", wb_en_out, 1'b0);
      check("nop_exe", exe_cmd, 4'h0);
      rst = 1'b0; instr_in = 32'hE0873002; wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h99;
      tick();
      check("midrst_valid", valid_out, 1'b0);
      rst = 1'b1; wb_en = 1'b0;
      tick();
      check("midrst_rf_rn", val_rn, 32'd7);
      check("midrst_rf_rm", val_rm, 32'd2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
